// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V funct3 access-size encodings
//   - FSM state encoding
//   - access_err(): decides whether a request is illegal or misaligned
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Unsigned variants exist only for loads. Halfwords must be 2-byte
    // aligned and words 4-byte aligned.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_BU:   err = we;
            F3_H:    err = offset[0];
            F3_HU:   err = we | offset[0];
            F3_W:    err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane handling for the LSU.
//   funct3     in   access size/sign
//   offset     in   byte offset inside the word
//   rword      in   word read from memory
//   wdata      in   right-aligned store data
//   load_data  out  addressed lane, sign- or zero-extended
//   merge_word out  rword with the addressed lane replaced by wdata
//                   (wdata itself for word stores)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default before
    // the case statements, so no path leaves it unassigned (no latch).
    always_comb begin
        // Little-endian: lane N sits at bits [8N +: 8].
        shifted    = rword >> {offset, 3'b000};
        load_data  = '0;
        merge_word = wdata;

        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rword;
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = '0;
        endcase

        case (funct3)
            F3_B: begin
                merge_word = rword;
                merge_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                // Halfword accesses are aligned, so offset[1] picks the lane.
                merge_word = rword;
                merge_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: merge_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RISC-V style load/store unit in front of a single-port word memory.
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr  store flag, access size/sign, byte address
//   req_wdata                     right-aligned store data
//   resp_valid                    one-cycle completion pulse
//   resp_rdata, resp_err          extended load data / misalign-illegal flag
//   MemRead, MemWrite             memory strobes (never both high)
//   mem_addr, mem_wdata           word address and write word
//   mem_rdata                     read word from memory
// Sub-word stores are read-modify-write: READ fetches the word, WRITE
// writes it back with one lane replaced.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       merge_word;

    // Gating with rst keeps ready low while reset is held even though the
    // state register already reads IDLE.
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = access_err(req_we, req_funct3, req_addr[1:0]);

    lsu_lane_align u_lane_align (
        .funct3     (f3_q),
        .offset     (off_q),
        .rword      (rdata_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                waddr_q <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state_q == ST_READ) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // All outputs decode from the state register, so an asynchronous reset
    // drops the strobes in the same instant it forces IDLE.
    always_comb begin
        state_d    = state_q;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = ST_RESP;
                    else if (req_we && req_funct3 == F3_W)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                MemRead  = 1'b1;
                mem_addr = waddr_q;
                state_d  = we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                MemWrite  = 1'b1;
                mem_addr  = waddr_q;
                mem_wdata = merge_word;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'h0 : load_data;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
